// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp FSM states and default duty/period sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the defaults keep this stage and the PWM counter in agreement.
package pwm_pkg;

    localparam int DUTY_W_DEF = 6;
    localparam int PERIOD_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/duty_sync_filter.sv
// Synchronises an asynchronous duty request and accepts it once it has been stable.
// Latency: a clean change reaches target_filt 2 + STABLE_CYCLES clocks after it appears.
// Backpressure: none; changes lasting fewer than STABLE_CYCLES samples are dropped.
module duty_sync_filter #(
    parameter int DUTY_W        = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target_in,
    output logic [DUTY_W-1:0] target_filt
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [DUTY_W-1:0] sync_q1;
    logic [DUTY_W-1:0] sync_q2;
    logic [DUTY_W-1:0] cand_q;
    logic [DUTY_W-1:0] cand_nxt;
    logic [CNT_W-1:0]  stab_cnt;
    logic [CNT_W-1:0]  stab_cnt_nxt;
    logic              differ;

    assign differ = (sync_q2 != cand_q);

    // A differing sample becomes the new candidate and restarts the run; equal samples extend it.
    always_comb begin
        cand_nxt     = differ ? sync_q2 : cand_q;
        stab_cnt_nxt = stab_cnt;
        if (differ) begin
            stab_cnt_nxt = '0;
        end else if (stab_cnt != CNT_LAST) begin
            stab_cnt_nxt = stab_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchroniser; bit skew across the bus is absorbed by the stability filter.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= target_in;
            sync_q2 <= sync_q1;
        end
    end

    // Track the candidate and publish it once the run reaches STABLE_CYCLES samples.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cand_q      <= '0;
            stab_cnt    <= '0;
            target_filt <= '0;
        end else begin
            cand_q   <= cand_nxt;
            stab_cnt <= stab_cnt_nxt;
            if (stab_cnt_nxt == CNT_LAST) begin
                target_filt <= cand_nxt;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty generator: moves duty_out toward the clamped target by <= STEP per period.
// Latency: duty/state change only on the clock after period_end (counter wrap to 0).
// Backpressure: none; the most recent effective target is used at each boundary.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int DUTY_W        = DUTY_W_DEF,
    parameter int PERIOD        = PERIOD_DEF,
    parameter int STEP          = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] target_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              period_end,
    output logic              ramping,
    output logic              at_target
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);
    localparam logic [DUTY_W:0]   STEP_W   = (DUTY_W + 1)'(STEP);

    ramp_state_t       state;
    ramp_state_t       state_nxt;
    logic [DUTY_W-1:0] target_filt;
    logic [DUTY_W-1:0] tgt_c;
    logic [DUTY_W-1:0] eff;
    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  per_cnt_nxt;
    logic [DUTY_W:0]   duty_w;
    logic [DUTY_W:0]   eff_w;
    logic [DUTY_W:0]   diff_w;
    logic [DUTY_W:0]   duty_nxt_w;

    duty_sync_filter #(
        .DUTY_W        (DUTY_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync_filter (
        .clk_in      (clk_in),
        .rst         (rst),
        .target_in   (target_in),
        .target_filt (target_filt)
    );

    // PERIOD means 100 % duty; anything above it is clamped. en low forces a soft-stop.
    assign tgt_c     = (target_filt > DUTY_MAX) ? DUTY_MAX : target_filt;
    assign eff       = en ? tgt_c : '0;
    assign at_target = (duty_out == eff);
    assign ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);

    assign per_cnt_nxt = (per_cnt == CNT_LAST) ? '0 : per_cnt + CNT_W'(1);

    // Free-running period counter; period_end is registered so it is high while the count is PERIOD-1.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            per_cnt    <= '0;
            period_end <= 1'b0;
        end else begin
            per_cnt    <= per_cnt_nxt;
            period_end <= (per_cnt_nxt == CNT_LAST);
        end
    end

    assign duty_w = {1'b0, duty_out};
    assign eff_w  = {1'b0, eff};

    // One slew step toward eff, limited to the remaining distance so it never overshoots.
    always_comb begin
        diff_w     = '0;
        duty_nxt_w = duty_w;
        if (duty_w < eff_w) begin
            diff_w     = eff_w - duty_w;
            duty_nxt_w = duty_w + ((diff_w < STEP_W) ? diff_w : STEP_W);
        end else if (duty_w > eff_w) begin
            diff_w     = duty_w - eff_w;
            duty_nxt_w = duty_w - ((diff_w < STEP_W) ? diff_w : STEP_W);
        end
        if (duty_nxt_w < eff_w) begin
            state_nxt = RAMP_UP;
        end else if (duty_nxt_w > eff_w) begin
            state_nxt = RAMP_DOWN;
        end else if (duty_nxt_w == '0) begin
            state_nxt = IDLE;
        end else begin
            state_nxt = HOLD;
        end
    end

    // Duty word and ramp state advance together, only at the period boundary.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            duty_out <= '0;
            state    <= IDLE;
        end else if (period_end) begin
            duty_out <= duty_nxt_w[DUTY_W-1:0];
            state    <= state_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: two instances (STEP=1 and STEP=4) share stimulus.
// Latency: outputs compared 1 ns after every rising edge against a behavioural model.
// Backpressure: n/a.
module tb_pwm_duty_ramp;

    localparam int DW = 6;
    localparam int P  = 32;
    localparam int SC = 4;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] target_in;
    logic [DW-1:0] duty_a, duty_b;
    logic          pe_a, pe_b, ramp_a, ramp_b, at_a, at_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int edges;
    int filt_m;
    int q[$];
    int duty_m[2];
    bit ramp_m[2];

    always #5 clk_in = ~clk_in;

    pwm_duty_ramp #(.DUTY_W(DW), .PERIOD(P), .STEP(1), .STABLE_CYCLES(SC)) dut_a (
        .clk_in(clk_in), .rst(rst), .en(en), .target_in(target_in),
        .duty_out(duty_a), .period_end(pe_a), .ramping(ramp_a), .at_target(at_a)
    );

    pwm_duty_ramp #(.DUTY_W(DW), .PERIOD(P), .STEP(4), .STABLE_CYCLES(SC)) dut_b (
        .clk_in(clk_in), .rst(rst), .en(en), .target_in(target_in),
        .duty_out(duty_b), .period_end(pe_b), .ramping(ramp_b), .at_target(at_b)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int eff_of(input int filt, input logic en_v);
        if (!en_v) return 0;
        return (filt > P) ? P : filt;
    endfunction

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        edges  = 0;
        filt_m = 0;
        q.delete();
        for (int i = 0; i < SC + 2; i++) q.push_back(0);
        for (int d = 0; d < 2; d++) begin
            duty_m[d] = 0;
            ramp_m[d] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic model_edge();
        int  eff;
        int  s;
        bit  same;
        edges++;
        eff = eff_of(filt_m, en);
        if (edges % P == 0) begin
            for (int d = 0; d < 2; d++) begin
                s = step_of(d);
                if (duty_m[d] < eff)
                    duty_m[d] += ((eff - duty_m[d]) < s) ? (eff - duty_m[d]) : s;
                else if (duty_m[d] > eff)
                    duty_m[d] -= ((duty_m[d] - eff) < s) ? (duty_m[d] - eff) : s;
                ramp_m[d] = (duty_m[d] != eff);
            end
        end
        // Filter sees the input delayed two clocks; accept after SC equal samples.
        q.push_back(int'(target_in));
        void'(q.pop_front());
        same = 1'b1;
        for (int i = 0; i < SC; i++) if (q[i] != q[SC-1]) same = 1'b0;
        if (same) filt_m = q[SC-1];
    endtask

    task automatic check_outputs();
        int eff;
        eff = eff_of(filt_m, en);
        check_val("duty_a",  int'(duty_a), duty_m[0]);
        check_val("duty_b",  int'(duty_b), duty_m[1]);
        check_val("pend_a",  int'(pe_a),   int'(edges % P == P - 1));
        check_val("pend_b",  int'(pe_b),   int'(edges % P == P - 1));
        check_val("ramp_a",  int'(ramp_a), int'(ramp_m[0]));
        check_val("ramp_b",  int'(ramp_b), int'(ramp_m[1]));
        check_val("attgt_a", int'(at_a),   int'(duty_m[0] == eff));
        check_val("attgt_b", int'(at_b),   int'(duty_m[1] == eff));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_duty_a"},  int'(duty_a), 0);
        check_val({tag, "_duty_b"},  int'(duty_b), 0);
        check_val({tag, "_pend_a"},  int'(pe_a),   0);
        check_val({tag, "_ramp_a"},  int'(ramp_a), 0);
        check_val({tag, "_ramp_b"},  int'(ramp_b), 0);
        check_val({tag, "_attgt_a"}, int'(at_a),   1);
        check_val({tag, "_attgt_b"}, int'(at_b),   1);
    endtask

    // Assert reset between edges; optionally check outputs before any clock edge.
    task automatic do_reset(input bit check_now);
        rst = 1'b1;
        #2;
        if (check_now) check_reset("rst_async");
        repeat (2) @(posedge clk_in);
        #1;
        check_reset("rst_held");
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        en        = 1'b1;
        target_in = DW'(10);
        model_reset();
        do_reset(1'b0);

        // Ramp 0 -> 10; STEP=4 instance goes 4, 8, 10
        run(32);  check_val("s4_first",  int'(duty_b), 4);
        run(32);  check_val("s4_second", int'(duty_b), 8);
        run(32);  check_val("s4_third",  int'(duty_b), 10);
        run(256);
        check_val("up10_duty",  int'(duty_a), 10);
        check_val("up10_ramp",  int'(ramp_a), 0);
        check_val("up10_attgt", int'(at_a),   1);

        // Short glitch to 20 must be ignored
        target_in = DW'(20);
        run(2);
        target_in = DW'(10);
        run(62);
        check_val("glitch_duty", int'(duty_a), 10);
        check_val("glitch_ramp", int'(ramp_a), 0);

        // Target 3: STEP=4 goes 6, 3
        target_in = DW'(3);
        run(32);  check_val("s4_down6", int'(duty_b), 6);
        run(32);  check_val("s4_down3", int'(duty_b), 3);
        run(224); check_val("down3_a",  int'(duty_a), 3);

        // Above PERIOD clamps at 100 %
        target_in = DW'(10);
        run(256);
        target_in = DW'(40);
        run(1024);
        check_val("clamp_a", int'(duty_a), P);
        check_val("clamp_b", int'(duty_b), P);

        // Soft-stop and restart
        target_in = DW'(10);
        run(768);
        en = 1'b0;
        run(384);
        check_val("stop_duty", int'(duty_a), 0);
        check_val("stop_ramp", int'(ramp_a), 0);
        en = 1'b1;
        run(384);
        check_val("restart_duty", int'(duty_a), 10);

        // Asynchronous reset mid-ramp at duty 5
        do_reset(1'b0);
        run(170);
        check_val("mid_duty", int'(duty_a), 5);
        do_reset(1'b1);
        run(30);
        check_val("post_rst_pend_lo", int'(pe_a), 0);
        tick();
        check_val("post_rst_pend_hi", int'(pe_a), 1);

        // Randomised targets, hold times and enable
        for (int seg = 0; seg < 60; seg++) begin
            target_in = DW'($urandom_range(0, 63));
            en        = ($urandom_range(0, 9) != 0);
            run(int'($urandom_range(1, 80)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
